// File: rtl/cond_issue_if.sv
// Bundles the instruction handshake, the ALU flag writeback and the issue/status outputs of cond_issue_ctrl.
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready; in_ready never depends on in_valid.
interface cond_issue_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_cond;
  logic       in_s;
  logic       flag_we;
  logic [3:0] flag_nzcv;
  logic       issue_valid;
  logic       issue_exec;
  logic       issue_s;
  logic [3:0] nzcv;
  logic [2:0] pend;
  logic [15:0] stall_cnt;
  logic       err;
  logic       fsm_state;

  modport slave (
    input  in_valid, in_cond, in_s, flag_we, flag_nzcv,
    output in_ready, issue_valid, issue_exec, issue_s, nzcv, pend, stall_cnt, err, fsm_state
  );

  modport master (
    output in_valid, in_cond, in_s, flag_we, flag_nzcv,
    input  in_ready, issue_valid, issue_exec, issue_s, nzcv, pend, stall_cnt, err, fsm_state
  );
endinterface

// File: rtl/cond_issue_ctrl.sv
// Conditional-issue controller: holds NZCV, evaluates ARM conditions, stalls on in-flight flag setters.
// Optional macro COND_ISSUE_FWD_EN forwards the last pending flag writeback to a waiting instruction.
module cond_issue_ctrl #(
  parameter int unsigned MAX_PEND = 3
) (
  input  logic       clk,
  input  logic       rst,
  cond_issue_if.slave bus
);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state, state_next;
  logic [3:0]  nzcv_q;
  logic [2:0]  pend_q;
  logic [15:0] stall_q;
  logic        err_q;
  logic        iss_valid_q, iss_exec_q, iss_s_q;

  logic        flag_dep, fwd, stall_a, stall_b, ready, accept;
  logic        exec, s_inc, flag_dec;
  logic [3:0]  eval_flags;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = !cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cf && !z;
      4'b1001: cond_pass = !cf || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign flag_dep = (bus.in_cond[3:1] != 3'b111);

`ifdef COND_ISSUE_FWD_EN
  // The writeback retiring the last pending setter can feed a non-S instruction directly.
  assign fwd = (pend_q == 3'd1) && bus.flag_we && !bus.in_s;
`else
  assign fwd = 1'b0;
`endif

  assign stall_a    = flag_dep && (pend_q != 3'd0) && !fwd;
  assign stall_b    = bus.in_s && (pend_q == 3'(MAX_PEND)) && !bus.flag_we;
  assign ready      = !rst && !stall_a && !stall_b;
  assign accept     = bus.in_valid && ready;
  assign eval_flags = fwd ? bus.flag_nzcv : nzcv_q;
  assign exec       = cond_pass(bus.in_cond, eval_flags);
  assign s_inc      = accept && bus.in_s && exec;
  assign flag_dec   = bus.flag_we && (pend_q != 3'd0);

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (bus.in_valid && !ready) state_next = S_WAIT;
      S_WAIT:  if (ready || !bus.in_valid) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      nzcv_q      <= 4'b0000;
      pend_q      <= 3'd0;
      stall_q     <= 16'd0;
      err_q       <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_exec_q  <= 1'b0;
      iss_s_q     <= 1'b0;
    end else begin
      state       <= state_next;
      iss_valid_q <= accept;
      iss_exec_q  <= accept && exec;
      iss_s_q     <= s_inc;
      if (bus.flag_we) begin
        if (pend_q != 3'd0) nzcv_q <= bus.flag_nzcv;
        else                err_q  <= 1'b1;
      end
      if (s_inc && !flag_dec)      pend_q <= pend_q + 3'd1;
      else if (flag_dec && !s_inc) pend_q <= pend_q - 3'd1;
      if (state == S_WAIT && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.issue_valid = iss_valid_q;
  assign bus.issue_exec  = iss_exec_q;
  assign bus.issue_s     = iss_s_q;
  assign bus.nzcv        = nzcv_q;
  assign bus.pend        = pend_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.err         = err_q;
  assign bus.fsm_state   = (state == S_WAIT);

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed bench for cond_issue_ctrl: expected issues are queued at acceptance and checked by a monitor.
module tb_cond_issue_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [1:0] exp_q[$];

  cond_issue_if bus();

  cond_issue_ctrl #(.MAX_PEND(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every issue pulse must match the oldest queued expectation {exec, s}
  always @(negedge clk) begin
    if (bus.issue_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 32'd1, 32'd0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("issue_exec", 32'(bus.issue_exec), 32'(e[1]));
        check("issue_s", 32'(bus.issue_s), 32'(e[0]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_instr(input logic [3:0] cond, input logic s, input logic exp_exec);
    bus.in_valid = 1'b1;
    bus.in_cond  = cond;
    bus.in_s     = s;
    #1;
    check("in_ready_accept", 32'(bus.in_ready), 32'd1);
    exp_q.push_back({exp_exec, s & exp_exec});
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic flag_wb(input logic [3:0] v);
    bus.flag_we   = 1'b1;
    bus.flag_nzcv = v;
    step();
    bus.flag_we   = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] v);
    send_instr(4'b1110, 1'b1, 1'b1);
    flag_wb(v);
    check("nzcv_loaded", 32'(bus.nzcv), 32'(v));
  endtask

  logic [15:0] tbl_0100;
  logic [15:0] tbl_1011;

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl_0100 = 16'h66A9;
    tbl_1011 = 16'h5556;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_cond   = 4'b0000;
    bus.in_s      = 1'b0;
    bus.flag_we   = 1'b0;
    bus.flag_nzcv = 4'b0000;
    step();
    step();
    bus.in_valid = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_nzcv", 32'(bus.nzcv), 32'd0);
    check("rst_pend", 32'(bus.pend), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();

    // EQ against NZCV=0000 squashes
    send_instr(4'b0000, 1'b0, 1'b0);

    // full condition table against two flag patterns
    load_flags(4'b0100);
    for (int c = 0; c < 16; c++) send_instr(4'(c), 1'b0, tbl_0100[c]);
    load_flags(4'b1011);
    for (int c = 0; c < 16; c++) send_instr(4'(c), 1'b0, tbl_1011[c]);
    check("pend_after_table", 32'(bus.pend), 32'd0);
    check("stall_none_yet", 32'(bus.stall_cnt), 32'd0);

    // GT waiting on a single flag setter
    send_instr(4'b1110, 1'b1, 1'b1);
    check("pend_one", 32'(bus.pend), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_cond  = 4'b1100;
    bus.in_s     = 1'b0;
    #1;
    check("gt_stall_c1", 32'(bus.in_ready), 32'd0);
    exp_q.push_back(2'b10);
    step();
    check("gt_stall_c2", 32'(bus.in_ready), 32'd0);
    check("fsm_wait", 32'(bus.fsm_state), 32'd1);
    step();
    bus.flag_we   = 1'b1;
    bus.flag_nzcv = 4'b0000;
    #1;
`ifdef COND_ISSUE_FWD_EN
    check("gt_fwd_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.flag_we  = 1'b0;
    bus.in_valid = 1'b0;
    check("gt_stall_cnt", 32'(bus.stall_cnt), 32'd2);
`else
    check("gt_stall_c3", 32'(bus.in_ready), 32'd0);
    step();
    bus.flag_we = 1'b0;
    #1;
    check("gt_ready_after_wb", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("gt_stall_cnt", 32'(bus.stall_cnt), 32'd3);
`endif
    check("gt_pend_zero", 32'(bus.pend), 32'd0);
    check("gt_nzcv", 32'(bus.nzcv), 32'd0);

    // MAX_PEND back-pressure with coincident acceptance and writeback
    send_instr(4'b1110, 1'b1, 1'b1);
    send_instr(4'b1110, 1'b1, 1'b1);
    send_instr(4'b1110, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_cond  = 4'b1110;
    bus.in_s     = 1'b1;
    #1;
    check("full_stall", 32'(bus.in_ready), 32'd0);
    check("full_pend", 32'(bus.pend), 32'd3);
    step();
    bus.flag_we   = 1'b1;
    bus.flag_nzcv = 4'b1001;
    #1;
    check("full_ready_on_wb", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(2'b11);
    step();
    bus.in_valid = 1'b0;
    bus.flag_we  = 1'b0;
    check("full_pend_hold", 32'(bus.pend), 32'd3);
    check("full_nzcv", 32'(bus.nzcv), 32'h9);
    flag_wb(4'b0010);
    flag_wb(4'b0100);
    flag_wb(4'b1000);
    check("drain_pend", 32'(bus.pend), 32'd0);
    check("drain_nzcv", 32'(bus.nzcv), 32'h8);
    check("err_clear", 32'(bus.err), 32'd0);

    // stray writeback
    flag_wb(4'b1111);
    check("err_set", 32'(bus.err), 32'd1);
    check("err_nzcv_kept", 32'(bus.nzcv), 32'h8);
    step();
    step();
    check("err_sticky", 32'(bus.err), 32'd1);

    // reset while stalled with two setters in flight
    send_instr(4'b1110, 1'b1, 1'b1);
    send_instr(4'b1110, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_cond  = 4'b0000;
    bus.in_s     = 1'b0;
    step();
    check("mid_wait_state", 32'(bus.fsm_state), 32'd1);
    check("mid_wait_pend", 32'(bus.pend), 32'd2);
    rst = 1'b1;
    bus.flag_we   = 1'b1;
    bus.flag_nzcv = 4'b1111;
    step();
    bus.flag_we = 1'b0;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("post_rst_pend", 32'(bus.pend), 32'd0);
    check("post_rst_nzcv", 32'(bus.nzcv), 32'd0);
    check("post_rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("post_rst_err", 32'(bus.err), 32'd0);
    check("post_rst_state", 32'(bus.fsm_state), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cond_issue_ctrl.md
# cond_issue_ctrl

Conditional-issue controller in front of the ALU and the NZCV condition-check logic. It holds the architectural NZCV flag register and accepts one instruction per cycle over a valid/ready handshake. It evaluates each instruction's 4-bit ARM condition field and issues the instruction downstream as execute or squash. It stalls flag-dependent instructions while flag-setting instructions are still in flight in the ALU.

## Interface
- MAX_PEND, default 3: maximum number of in-flight flag-setting instructions (1..7).
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  instruction presented.
- IN_READY  output  1  controller accepts the instruction this cycle.
- IN_COND  input  4  ARM condition field.
- IN_S  input  1  instruction writes flags if executed.
- FLAG_WE  input  1  ALU flag writeback strobe.
- FLAG_NZCV  input  4  writeback value; [3]=N, [2]=Z, [1]=C, [0]=V.
- ISSUE_VALID  output  1  one-cycle pulse; an instruction is issued.
- ISSUE_EXEC  output  1  1 = execute, 0 = squash (NOP).
- ISSUE_S  output  1  IN_S gated by ISSUE_EXEC.
- NZCV  output  4  architectural flags.
- PEND  output  3  in-flight flag-setter count.
- STALL_CNT  output  16  saturating count of stall cycles.
- ERR  output  1  sticky: FLAG_WE arrived while PEND==0.

## Operation
- Condition evaluation (standard ARM):
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z.
  - GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - 1110 AL always.
  - 1111 never (squash).
- Flag-dependent: every IN_COND except 1110 and 1111.
- Handshake: an instruction is accepted when IN_VALID & IN_READY at a rising edge.
- Stall conditions (IN_READY=0):
  - (a) the instruction is flag-dependent and PEND!=0, unless forwarding applies (see Configuration);
  - (b) IN_S=1 and PEND==MAX_PEND and FLAG_WE=0.
- IN_READY is combinational from the inputs and state; it is 0 while RST=1.
- PEND:
  - +1 when an accepted instruction has ISSUE_S=1;
  - -1 on FLAG_WE when PEND>0;
  - unchanged when both events occur in the same cycle.
- A squashed S instruction does not increment PEND.
- FLAG_WE loads NZCV<=FLAG_NZCV when PEND>0. When PEND==0 it is ignored and ERR<=1.
- FSM states:
  - RUN: no stall. Go to WAIT when IN_VALID=1 and IN_READY=0.
  - WAIT: stalling. Return to RUN on the first cycle IN_READY=1 or IN_VALID=0.
- STALL_CNT increments every cycle spent in WAIT and saturates at 16'hFFFF.
- No downstream backpressure; issue is never withheld once an instruction is accepted.

## Timing
- Reset values:
  - IN_READY=0; ISSUE_VALID=0; ISSUE_EXEC=0; ISSUE_S=0.
  - NZCV=4'b0000; PEND=0; STALL_CNT=0; ERR=0.
  - FSM=RUN.
- Reset mid-stall drops the pending instruction and all in-flight accounting. A FLAG_WE in the reset cycle is ignored.
- Issue latency: ISSUE_VALID, ISSUE_EXEC and ISSUE_S are registered and assert in the cycle after acceptance, for exactly one cycle.
- ISSUE_EXEC uses NZCV as it stood in the acceptance cycle, or FLAG_NZCV when forwarding is used.
- Same-cycle acceptance and FLAG_WE: the flag update does not affect that instruction's evaluation except through forwarding.
- Flag-dependent instruction waiting on the last writeback:
  - without forwarding: accepted in the cycle after the FLAG_WE that drives PEND to 0;
  - with forwarding: accepted in the FLAG_WE cycle itself.
- PEND, NZCV and STALL_CNT update at the rising edge.

## Configuration
- COND_ISSUE_FWD_EN defined:
  - when PEND==1, FLAG_WE=1 and no S instruction is accepted in the same cycle, a flag-dependent instruction is accepted that cycle;
  - it is evaluated against FLAG_NZCV.
- COND_ISSUE_FWD_EN undefined: flag-dependent instructions evaluate only against the registered NZCV, costing one extra stall cycle.

## Test plan
- Reset, then IN_VALID=1, COND=0000 (EQ), S=0 with NZCV=0000 -> IN_READY=1; next cycle ISSUE_VALID=1, ISSUE_EXEC=0.
- All 16 COND values, each against flags NZCV=0100 and NZCV=1011 preloaded via an S-AL instruction plus FLAG_WE -> ISSUE_EXEC matches the ARM table; COND=1111 always 0; COND=1110 always 1.
- S-AL accepted (PEND->1), then GT presented, FLAG_WE with 0000 three cycles later:
  - without the macro: stall of 3 cycles, acceptance in the cycle after FLAG_WE, ISSUE_EXEC=1, STALL_CNT=3;
  - with the macro: acceptance in the FLAG_WE cycle, STALL_CNT=2.
- MAX_PEND=3: four back-to-back S-AL instructions -> the fourth stalls until FLAG_WE; PEND stays 3 while acceptance and FLAG_WE coincide.
- FLAG_WE with PEND==0 -> ERR=1, NZCV unchanged; ERR stays 1 until RST.
- RST asserted during WAIT with PEND=2 -> the following cycle shows IN_READY=0, PEND=0, NZCV=0000, ISSUE_VALID=0.
